fetch_decode_buffer: RTL
========================

# fetch_decode_buffer

Parametrised IF/ID boundary buffer that replaces the plain enable/flush pipeline register between fetch and decode. It carries {instruction, PC, PC+4} through a DEPTH-entry FIFO with valid/ready handshakes on both sides, so fetch can keep issuing while decode stalls. It presents a canonical NOP bubble when empty, supports synchronous flush on branch or jump redirect, and exposes occupancy and a saturating stall counter for performance analysis.

## Interface
- DATA_WIDTH, 32, width of instruction, PC and PC+4 fields
- DEPTH, 2, number of buffered entries; power of two, ≥ 2
- NOP_INSTR, 32'h0000_0013, instruction driven on instrD when empty (addi x0,x0,0)
- CNT_WIDTH, 16, width of stall counter
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all entries (redirect)
- in_valid  in  1  fetch offers an entry
- in_ready  out  1  buffer can accept; = (count < DEPTH)
- instrF / PCF / PCPlus4F  in  DATA_WIDTH each  fetch payload
- out_valid  out  1  head entry present; = (count != 0)
- out_ready  in  1  decode consumes head this cycle
- instrD / PCD / PCPlus4D  out  DATA_WIDTH each  head payload, or bubble when empty
- count  out  $clog2(DEPTH+1)  current occupancy
- stall_cnt  out  CNT_WIDTH  cycles with out_valid && !out_ready, saturating

## Operation
- push = in_valid && in_ready && !flush; pop = out_valid && out_ready && !flush.
- push writes payload at wr_ptr, wr_ptr++ (mod DEPTH); pop advances rd_ptr++ (mod DEPTH).
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full (count==DEPTH): in_ready=0; no same-cycle pass-through when a pop occurs — in_ready depends only on registered count.
- Empty: out_valid=0, instrD=NOP_INSTR, PCD=0, PCPlus4D=0. No bypass from input to output.
- Flush: next-edge count=0, wr_ptr=rd_ptr=0; the same-cycle push and pop are both discarded. Flush dominates all other events.
- stall_cnt increments when out_valid && !out_ready, holds at all-ones, and is cleared only by rst_n (flush does not clear it).
- Reset (asserted at any time, including mid-transfer): count=0, pointers=0, stall_cnt=0. Outputs immediately read as empty and bubble: out_valid=0, in_ready=1, instrD=NOP_INSTR, PCD=PCPlus4D=0.

## Timing
- Latency: an entry pushed at edge N appears on the outputs during cycle N+1.
- Throughput: 1 entry/cycle sustained while out_ready=1 and in_valid=1 (count stays 1 for DEPTH≥2).
- All outputs are functions of registered state only; no combinational in→out path.
- in_ready and out_valid are valid from the first cycle after rst_n deasserts.
- Storage has no reset requirement (payload regs may be non-reset); outputs must still show the bubble when empty.

## Structure
- Package pipe_pkg: NOP_INSTR constant; typedef struct packed fd_payload_t {instr, pc, pc_plus4}.
- Sub-module pipe_fifo (generic width/depth circular buffer with count, flush, async reset), instantiated with $bits(fd_payload_t). The top handles the bubble mux and stall_cnt.

## Test plan
- Reset: hold rst_n=0 mid-stream with 2 entries → immediately out_valid=0, instrD=0x00000013, count=0, in_ready=1, stall_cnt=0.
- Streaming: push instrs 0xA0..0xA7 at PC 0x100+4k with out_ready=1 → same sequence out, 1-cycle latency, no gaps, count never >1.
- Backpressure: out_ready=0 with in_valid=1 for 5 cycles, DEPTH=2 → count=2, in_ready=0 from cycle 3, stall_cnt=4; release out_ready → entries drain in order, nothing lost or duplicated.
- Full + pop: count=2, in_valid=1, out_ready=1 → pop occurs, push refused that cycle (count=1 next); offered entry accepted the following cycle.
- Flush collision: count=1, assert flush with in_valid=1 and out_ready=1 → next cycle count=0, bubble on outputs; stall_cnt unchanged.
- Saturation: CNT_WIDTH=4, stall 20 cycles → stall_cnt=15 and holds.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the IF/ID boundary buffer.
// The payload struct fixes the field order {instr, pc, pc_plus4} used by the FIFO storage.
package pipe_pkg;

    localparam int FD_WIDTH = 32;

    // addi x0,x0,0: the canonical bubble presented to decode when nothing is buffered
    localparam logic [FD_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FD_WIDTH-1:0] instr;
        logic [FD_WIDTH-1:0] pc;
        logic [FD_WIDTH-1:0] pc_plus4;
    } fd_payload_t;

endpackage

// File: rtl/pipe_fifo.sv
// Generic circular-buffer FIFO with valid/ready on both sides, occupancy count and flush.
// Handshake outputs depend on registered count only, so there is no pass-through when full.
module pipe_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] wdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign rdata     = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally at their width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_decode_buffer.sv
// IF/ID boundary buffer: a small FIFO of {instr, PC, PC+4} between fetch and decode,
// presenting a NOP bubble when empty and counting decode stall cycles.
module fetch_decode_buffer
    import pipe_pkg::fd_payload_t;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = pipe_pkg::NOP_INSTR,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      instrF,
    input  logic [DATA_WIDTH-1:0]      PCF,
    input  logic [DATA_WIDTH-1:0]      PCPlus4F,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      instrD,
    output logic [DATA_WIDTH-1:0]      PCD,
    output logic [DATA_WIDTH-1:0]      PCPlus4D,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_WIDTH-1:0]       stall_cnt
);

    fd_payload_t wr_payload;
    fd_payload_t rd_payload;

    assign wr_payload = {instrF, PCF, PCPlus4F};

    pipe_fifo #(
        .WIDTH ($bits(fd_payload_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wdata     (wr_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rdata     (rd_payload),
        .count     (count)
    );

    // Storage is not reset, so the bubble mux is what guarantees clean outputs when empty
    assign instrD   = out_valid ? rd_payload.instr    : NOP_INSTR;
    assign PCD      = out_valid ? rd_payload.pc       : '0;
    assign PCPlus4D = out_valid ? rd_payload.pc_plus4 : '0;

    // Saturating stall counter; deliberately survives flush so redirects don't hide stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
